// File: rtl/ysyx_25020047_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencer: FSM encoding,
// IDU one-hot inst_type bit positions, halt codes and the instruction classifier.
package ysyx_25020047_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_I   = 3'd2,
    ST_DECODE   = 3'd3,
    ST_MEM_REQ  = 3'd4,
    ST_MEM_WAIT = 3'd5,
    ST_WB       = 3'd6,
    ST_HALT     = 3'd7
  } ctrl_state_e;

  localparam int IT_LW  = 5;
  localparam int IT_LBU = 6;
  localparam int IT_SW  = 7;
  localparam int IT_SB  = 8;
  localparam int IT_SH  = 21;
  localparam int IT_BEQ = 14;
  localparam int IT_BNE = 15;

  localparam logic [31:0] IT_EBREAK  = 32'h0000_0004;
  localparam logic [31:0] IT_ILLEGAL = 32'hFFFF_FFFF;

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_EBREAK  = 2'd1;
  localparam logic [1:0] HALT_ILLEGAL = 2'd2;
  localparam logic [1:0] HALT_TIMEOUT = 2'd3;

  typedef struct packed {
    logic load;
    logic store;
    logic nowb;
    logic ebreak;
    logic illegal;
  } inst_class_t;

  function automatic inst_class_t classify(input logic [31:0] it);
    inst_class_t c;
    c.load    = it[IT_LW] | it[IT_LBU];
    c.store   = it[IT_SW] | it[IT_SB] | it[IT_SH];
    c.nowb    = c.store | it[IT_BEQ] | it[IT_BNE];
    c.ebreak  = (it == IT_EBREAK);
    c.illegal = (it == IT_ILLEGAL);
    return c;
  endfunction

endpackage

// File: rtl/ysyx_25020047_ctrl_if.sv
// Fetch and load/store handshake bundle between the sequencer (master) and the
// IFU/LSU side (slave).
interface ysyx_25020047_ctrl_if;
  // Valid/ready: a request valid stays high until the cycle its ready is sampled
  // high; the matching rsp_valid is only honoured from the following cycle on.
  logic ifu_req_valid;
  logic ifu_req_ready;
  logic ifu_rsp_valid;
  logic inst_en;
  logic lsu_req_valid;
  logic lsu_req_wen;
  logic lsu_req_ready;
  logic lsu_rsp_valid;

  modport master (
    output ifu_req_valid, inst_en, lsu_req_valid, lsu_req_wen,
    input  ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid
  );

  modport slave (
    input  ifu_req_valid, inst_en, lsu_req_valid, lsu_req_wen,
    output ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid
  );
endinterface

// File: rtl/ysyx_25020047_wdog.sv
// Bus watchdog: counts consecutive enabled cycles; expired flags the TIMEOUT-th
// such cycle so the FSM can leave on that same edge.
module ysyx_25020047_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  // cnt holds the cycles already spent, so the current cycle is number cnt+1
  assign expired = en && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_25020047_ctrl.sv
// NPC multi-cycle sequencer: fetch / decode / memory / write-back handshakes,
// commit strobes, cycle and retire counters, and a bus watchdog halt.
module ysyx_25020047_ctrl
  import ysyx_25020047_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           inst_type,
  ysyx_25020047_ctrl_if.master  bus,
  output logic                  reg_wen,
  output logic                  pc_wen,
  output logic                  halt,
  output logic [1:0]            halt_code,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      mcycle,
  output logic [CNT_W-1:0]      minstret
);

  ctrl_state_e st, st_nxt;
  logic [1:0]  code_nxt;
  inst_class_t cls;
  logic        store_q, nowb_q;
  logic        store_sel, nowb_sel;
  logic        watched, wd_clr, wd_expired;

  assign state = st;

  always_comb begin
    cls      = classify(inst_type);
    watched  = st inside {ST_FETCH, ST_WAIT_I, ST_MEM_REQ, ST_MEM_WAIT};
    st_nxt   = st;
    code_nxt = halt_code;
    case (st)
      ST_IDLE:     st_nxt = ST_FETCH;
      ST_FETCH:    if (bus.ifu_req_ready) st_nxt = ST_WAIT_I;
      ST_WAIT_I:   if (bus.ifu_rsp_valid) st_nxt = ST_DECODE;
      ST_DECODE: begin
        if (cls.illegal) begin
          st_nxt   = ST_HALT;
          code_nxt = HALT_ILLEGAL;
        end else if (cls.ebreak) begin
          st_nxt   = ST_HALT;
          code_nxt = HALT_EBREAK;
        end else if (cls.load || cls.store) begin
          st_nxt = ST_MEM_REQ;
        end else begin
          st_nxt = ST_WB;
        end
      end
      ST_MEM_REQ:  if (bus.lsu_req_ready) st_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (bus.lsu_rsp_valid) st_nxt = ST_WB;
      ST_WB:       st_nxt = ST_FETCH;
      ST_HALT:     st_nxt = ST_HALT;
      default:     st_nxt = ST_IDLE;
    endcase
    // A legitimate exit already changed st_nxt, so it takes priority here
    if (watched && (st_nxt == st) && wd_expired) begin
      st_nxt   = ST_HALT;
      code_nxt = HALT_TIMEOUT;
    end
    wd_clr    = !watched || (st_nxt != st);
    store_sel = (st == ST_DECODE) ? cls.store : store_q;
    nowb_sel  = (st == ST_DECODE) ? cls.nowb  : nowb_q;
  end

  ysyx_25020047_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (watched),
    .expired (wd_expired)
  );

  // Every output is a flop loaded from the next state, so it tracks the state
  // register exactly and no input reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st                <= ST_IDLE;
      halt              <= 1'b0;
      halt_code         <= HALT_NONE;
      bus.ifu_req_valid <= 1'b0;
      bus.inst_en       <= 1'b0;
      bus.lsu_req_valid <= 1'b0;
      bus.lsu_req_wen   <= 1'b0;
      reg_wen           <= 1'b0;
      pc_wen            <= 1'b0;
      store_q           <= 1'b0;
      nowb_q            <= 1'b0;
      mcycle            <= '0;
      minstret          <= '0;
    end else begin
      st                <= st_nxt;
      halt              <= (st_nxt == ST_HALT);
      halt_code         <= code_nxt;
      bus.ifu_req_valid <= (st_nxt == ST_FETCH);
      bus.inst_en       <= (st_nxt == ST_DECODE);
      bus.lsu_req_valid <= (st_nxt == ST_MEM_REQ);
      bus.lsu_req_wen   <= (st_nxt == ST_MEM_REQ) && store_sel;
      pc_wen            <= (st_nxt == ST_WB);
      reg_wen           <= (st_nxt == ST_WB) && !nowb_sel;
      if (st == ST_DECODE) begin
        store_q <= cls.store;
        nowb_q  <= cls.nowb;
      end
      if (st != ST_HALT) mcycle <= mcycle + CNT_W'(1);
      if (st == ST_WB) minstret <= minstret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_ctrl.sv
// Self-checking bench for ysyx_25020047_ctrl: an IFU/LSU responder with random
// delays and bus noise, checked against a transaction-level timing model.
`timescale 1ns/1ps
module tb_ysyx_25020047_ctrl;
  import ysyx_25020047_pkg::*;

  localparam int TO = 8;
  localparam int CW = 32;

  typedef enum int {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_EBREAK, C_ILLEGAL} cls_e;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   inst_type = 32'h0;
  logic          reg_wen, pc_wen, halt;
  logic [1:0]    halt_code;
  logic [2:0]    state;
  logic [CW-1:0] mcycle, minstret;

  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] exp_ret = '0;
  logic [CW-1:0] since_rst;

  ysyx_25020047_ctrl_if bus();

  ysyx_25020047_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_type (inst_type),
    .bus       (bus),
    .reg_wen   (reg_wen),
    .pc_wen    (pc_wen),
    .halt      (halt),
    .halt_code (halt_code),
    .state     (state),
    .mcycle    (mcycle),
    .minstret  (minstret)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) since_rst <= '0;
    else     since_rst <= since_rst + 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  // ---------------- reference model ----------------
  function automatic cls_e model_class(input logic [31:0] it);
    if (it == 32'hFFFF_FFFF) return C_ILLEGAL;
    if (it == 32'h0000_0004) return C_EBREAK;
    if (it[5] | it[6]) return C_LOAD;
    if (it[7] | it[8] | it[21]) return C_STORE;
    if (it[14] | it[15]) return C_BRANCH;
    return C_ALU;
  endfunction

  function automatic logic coin();
    return ($urandom_range(0, 1) == 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ret = '0;
    @(negedge clk);
  endtask

  // Runs one instruction from its first FETCH cycle (entered at a negedge) to
  // the next FETCH or HALT. d_* are the wait cycles before each ready/response.
  task automatic run_inst(input logic [31:0] it, input int d_ir, input int d_is,
                          input int d_mr, input int d_ms, input bit abort_in_mem,
                          output bit aborted);
    cls_e c;
    bit   mem, done, dec_next;
    int   phase, cnt, cyc, exp_code, exp_lat, exp_halt_at;
    int   n_ie, ie_at, n_lv, n_wen_bad, n_pc, n_reg, halt_at;
    logic [CW-1:0] frz;
    c = model_class(it);
    mem = (c == C_LOAD) || (c == C_STORE);
    phase = 0; cnt = 0; cyc = 0; done = 0; dec_next = 0; aborted = 0;
    n_ie = 0; ie_at = -1; n_lv = 0; n_wen_bad = 0; n_pc = 0; n_reg = 0; halt_at = -1;

    exp_code = 0;
    exp_halt_at = -1;
    if (d_ir >= TO) begin
      exp_code = 3; exp_halt_at = 1 + TO;
    end else if (d_is >= TO) begin
      exp_code = 3; exp_halt_at = d_ir + 2 + TO;
    end else if (c == C_ILLEGAL) begin
      exp_code = 2; exp_halt_at = d_ir + d_is + 4;
    end else if (c == C_EBREAK) begin
      exp_code = 1; exp_halt_at = d_ir + d_is + 4;
    end else if (mem && d_mr >= TO) begin
      exp_code = 3; exp_halt_at = d_ir + d_is + 4 + TO;
    end else if (mem && d_ms >= TO) begin
      exp_code = 3; exp_halt_at = d_ir + d_is + d_mr + 5 + TO;
    end
    exp_lat = (d_ir + 1) + (d_is + 1) + 1 + (mem ? (d_mr + 1) + (d_ms + 1) : 0) + 1 + 1;

    checks++;
    if (bus.ifu_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL start_fetch it=%h: ifu_req_valid=%b required 1", it, bus.ifu_req_valid);
    end

    while (1) begin
      cyc++;
      if (bus.inst_en) begin n_ie++; ie_at = cyc; end
      if (bus.lsu_req_valid) begin
        n_lv++;
        if (bus.lsu_req_wen !== (c == C_STORE)) n_wen_bad++;
      end
      if (pc_wen) n_pc++;
      if (reg_wen) n_reg++;
      if (halt) begin
        halt_at = cyc; done = 1;
      end else if (phase >= 2 && bus.ifu_req_valid) begin
        done = 1;
      end else if (cyc > 300) begin
        checks++; errors++;
        $display("FAIL cycle_budget it=%h: no commit after %0d cycles", it, cyc);
        done = 1;
      end
      clear_inputs();
      inst_type = dec_next ? it : $urandom;
      dec_next = 0;
      if (done) break;
      case (phase)
        0: begin
          if (bus.ifu_req_valid) begin
            if (cnt == d_ir) begin bus.ifu_req_ready = 1'b1; phase = 1; cnt = 0; end
            else cnt++;
          end
          bus.ifu_rsp_valid = coin();
          bus.lsu_req_ready = coin();
          bus.lsu_rsp_valid = coin();
        end
        1: begin
          if (cnt == d_is) begin
            bus.ifu_rsp_valid = 1'b1; phase = 2; cnt = 0; dec_next = 1;
          end else cnt++;
          bus.ifu_req_ready = coin();
          bus.lsu_req_ready = coin();
          bus.lsu_rsp_valid = coin();
        end
        2: begin
          if (bus.lsu_req_valid) begin
            if (cnt == d_mr) begin bus.lsu_req_ready = 1'b1; phase = 3; cnt = 0; end
            else cnt++;
          end
          bus.ifu_req_ready = coin();
          bus.ifu_rsp_valid = coin();
          bus.lsu_rsp_valid = coin();
        end
        3: begin
          if (abort_in_mem && cnt == 2) begin aborted = 1; break; end
          if (cnt == d_ms) begin bus.lsu_rsp_valid = 1'b1; phase = 4; end
          else cnt++;
          bus.ifu_req_ready = coin();
          bus.ifu_rsp_valid = coin();
          bus.lsu_req_ready = coin();
        end
        default: begin
          bus.ifu_rsp_valid = coin();
          bus.lsu_req_ready = coin();
          bus.lsu_rsp_valid = coin();
        end
      endcase
      @(negedge clk);
    end

    if (aborted) return;

    if (exp_code == 0) begin
      checks++;
      if (cyc !== exp_lat) begin
        errors++;
        $display("FAIL latency it=%h: next fetch at cycle %0d required %0d", it, cyc, exp_lat);
      end
      checks++;
      if (n_ie !== 1 || ie_at !== d_ir + d_is + 3) begin
        errors++;
        $display("FAIL inst_en it=%h: %0d pulses at cycle %0d required 1 at %0d", it, n_ie, ie_at, d_ir + d_is + 3);
      end
      checks++;
      if (n_lv !== (mem ? d_mr + 1 : 0)) begin
        errors++;
        $display("FAIL lsu_req_valid it=%h: high %0d cycles required %0d", it, n_lv, mem ? d_mr + 1 : 0);
      end
      checks++;
      if (n_wen_bad !== 0) begin
        errors++;
        $display("FAIL lsu_req_wen it=%h: %0d wrong cycles required 0", it, n_wen_bad);
      end
      checks++;
      if (n_pc !== 1) begin
        errors++;
        $display("FAIL pc_wen it=%h: %0d pulses required 1", it, n_pc);
      end
      checks++;
      if (n_reg !== ((c == C_ALU || c == C_LOAD) ? 1 : 0)) begin
        errors++;
        $display("FAIL reg_wen it=%h: %0d pulses required %0d", it, n_reg, (c == C_ALU || c == C_LOAD) ? 1 : 0);
      end
      exp_ret = exp_ret + 1'b1;
      checks++;
      if (minstret !== exp_ret) begin
        errors++;
        $display("FAIL minstret it=%h: got %0d required %0d", it, minstret, exp_ret);
      end
      checks++;
      if (mcycle !== since_rst) begin
        errors++;
        $display("FAIL mcycle it=%h: got %0d required %0d", it, mcycle, since_rst);
      end
    end else begin
      checks++;
      if (halt_code !== 2'(exp_code) || halt_at !== exp_halt_at) begin
        errors++;
        $display("FAIL halt it=%h: code %0d at cycle %0d required code %0d at %0d", it, halt_code, halt_at, exp_code, exp_halt_at);
      end
      checks++;
      if (n_pc !== 0 || n_reg !== 0) begin
        errors++;
        $display("FAIL halt_commit it=%h: pc_wen %0d reg_wen %0d pulses required 0", it, n_pc, n_reg);
      end
      checks++;
      if (minstret !== exp_ret) begin
        errors++;
        $display("FAIL halt_minstret it=%h: got %0d required %0d", it, minstret, exp_ret);
      end
      frz = since_rst;
      repeat (3) @(negedge clk);
      checks++;
      if (mcycle !== frz || halt !== 1'b1 || halt_code !== 2'(exp_code)) begin
        errors++;
        $display("FAIL halt_frozen it=%h: mcycle %0d halt %b code %0d required %0d 1 %0d", it, mcycle, halt, halt_code, frz, exp_code);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", state, ST_IDLE);
    end
    checks++;
    if ({bus.ifu_req_valid, bus.inst_en, bus.lsu_req_valid, bus.lsu_req_wen, reg_wen, pc_wen, halt} !== 7'b0
        || halt_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_strobes: got %b code %0d required all 0",
               {bus.ifu_req_valid, bus.inst_en, bus.lsu_req_valid, bus.lsu_req_wen, reg_wen, pc_wen, halt}, halt_code);
    end
    checks++;
    if (mcycle !== '0 || minstret !== '0) begin
      errors++;
      $display("FAIL reset_counters: mcycle %0d minstret %0d required 0 0", mcycle, minstret);
    end
    rst = 1'b0;
    exp_ret = '0;
    @(negedge clk);
    checks++;
    if (bus.ifu_req_valid !== 1'b1 || state !== ST_FETCH || mcycle !== 1) begin
      errors++;
      $display("FAIL reset_release: valid %b state %0d mcycle %0d required 1 %0d 1", bus.ifu_req_valid, state, mcycle, ST_FETCH);
    end
  endtask

  task automatic test_basic();
    bit ab;
    run_inst(32'h1, 0, 0, 0, 0, 0, ab);          // addi, minimum latency
    run_inst(32'h1, 1, 1, 0, 0, 0, ab);          // addi, one-cycle waits
    run_inst(32'h20, 0, 0, 3, 0, 0, ab);         // lw, ready held off 3 cycles
    run_inst(32'h80, 0, 1, 0, 2, 0, ab);         // sw
    run_inst(32'h4000, 0, 0, 0, 0, 0, ab);       // beq
  endtask

  task automatic test_halts();
    bit ab;
    do_reset();
    run_inst(32'h1, 0, 0, 0, 0, 0, ab);
    run_inst(32'h4, 1, 0, 0, 0, 0, ab);          // ebreak
    do_reset();
    run_inst(32'hFFFF_FFFF, 0, 2, 0, 0, 0, ab);  // illegal
  endtask

  task automatic test_timeout();
    bit ab;
    do_reset();
    run_inst(32'h1, 0, TO - 1, 0, 0, 0, ab);     // response on the last allowed cycle
    run_inst(32'h20, TO - 1, 0, TO - 1, TO - 1, 0, ab);
    run_inst(32'h1, 0, 100, 0, 0, 0, ab);        // response never comes
    do_reset();
    run_inst(32'h1, 100, 0, 0, 0, 0, ab);        // fetch never accepted
    do_reset();
    run_inst(32'h40, 0, 0, 0, 100, 0, ab);       // load data never returns
  endtask

  task automatic test_back_to_back();
    bit ab;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_inst((i % 2 == 0) ? 32'h1 : 32'h100, 0, 0, 0, 0, 0, ab);
    end
  endtask

  task automatic test_random();
    bit ab;
    logic [31:0] it;
    int b;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: it = 32'h1;
        1: it = 32'h20;
        2: it = 32'h40;
        3: it = 32'h80;
        4: it = 32'h100;
        5: it = 32'h20_0000;
        6: it = 32'h4000;
        7: it = 32'h8000;
        default: begin
          b = $urandom_range(0, 31);
          if (b == 2) b = 3;
          it = 32'h1 << b;
        end
      endcase
      run_inst(it, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, ab);
    end
  endtask

  task automatic test_reset_mid_mem();
    bit ab;
    do_reset();
    run_inst(32'h1, 0, 0, 0, 0, 0, ab);
    run_inst(32'h8000, 0, 0, 0, 0, 0, ab);
    run_inst(32'h20, 0, 0, 0, 20, 1, ab);
    checks++;
    if (ab !== 1'b1 || state !== ST_MEM_WAIT) begin
      errors++;
      $display("FAIL mid_mem_reach: aborted %b state %0d required 1 %0d", ab, state, ST_MEM_WAIT);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (state !== ST_IDLE
        || {bus.ifu_req_valid, bus.inst_en, bus.lsu_req_valid, bus.lsu_req_wen, reg_wen, pc_wen, halt} !== 7'b0) begin
      errors++;
      $display("FAIL mid_mem_async_reset: state %0d strobes %b required %0d 0", state,
               {bus.ifu_req_valid, bus.inst_en, bus.lsu_req_valid, bus.lsu_req_wen, reg_wen, pc_wen, halt}, ST_IDLE);
    end
    checks++;
    if (mcycle !== '0 || minstret !== '0) begin
      errors++;
      $display("FAIL mid_mem_counters: mcycle %0d minstret %0d required 0 0", mcycle, minstret);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_ret = '0;
    @(negedge clk);
    checks++;
    if (bus.ifu_req_valid !== 1'b1 || bus.lsu_req_valid !== 1'b0 || mcycle !== 1) begin
      errors++;
      $display("FAIL mid_mem_restart: ifu %b lsu %b mcycle %0d required 1 0 1", bus.ifu_req_valid, bus.lsu_req_valid, mcycle);
    end
    run_inst(32'h20, 0, 0, 1, 1, 0, ab);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_halts();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
